spi_bus_arbiter: RTL and testbench

Shares one physical SPI pin group between NumReq SPI host requesters. Typical pin groups are the application flash (appspi_*) or a header SPI bus. Grants exclusive ownership round-robin, muxes SCLK/COPI/CS from the owner to the pins and routes CIPO back to the owner only. Enforces a chip-select-high guard gap between owners so that a flash never sees a partial or merged transaction. Sits between the SPI host instances in the system and the pin-output assignments at top level.

---
 rtl/spi_bus_arbiter_pkg.sv | 5 +
 rtl/spi_bus_arbiter_rr_pick.sv | 28 ++
 rtl/spi_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_spi_bus_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_bus_arbiter_pkg.sv
// spi_bus_arbiter_pkg: shared state encoding and limits for the SPI pin-group arbiter.
package spi_bus_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_GAP} arb_state_e;
  localparam int NumReqMax = 8;
endpackage

// File: rtl/spi_bus_arbiter_rr_pick.sv
// spi_bus_arbiter_rr_pick: combinational round-robin picker, first set request at or above ptr_i (wrapping).
module spi_bus_arbiter_rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o,
  output logic [N-1:0] onehot_o
);
  int k;
  // Walk offsets from farthest to nearest so the nearest hit is the last one written.
  always_comb begin
    valid_o = |req_i;
    idx_o = '0;
    onehot_o = '0;
    k = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr_i) + i) % N;
      if (req_i[k]) begin
        idx_o = W'(k);
        onehot_o = '0;
        onehot_o[k] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin owner of one SPI pin group with a CS-high guard gap between owners.
// Define SPI_BUS_ARBITER_TIMEOUT_EN to bound grant length and lock out a revoked requester.
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int NumReq = 2,
  parameter int GapCycles = 4,
  parameter int TimeoutCycles = 65535,
  localparam int OwnerW = (NumReq > 2) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [OwnerW-1:0] owner_o,
  output logic              busy_o,
  output logic              timeout_o,
  input  logic [NumReq-1:0] req_sclk_i,
  input  logic [NumReq-1:0] req_copi_i,
  input  logic [NumReq-1:0] req_cs_ni,
  output logic [NumReq-1:0] req_cipo_o,
  output logic              spi_sclk_o,
  output logic              spi_copi_o,
  output logic              spi_cs_no,
  input  logic              spi_cipo_i
);
  localparam int GapW = $clog2(GapCycles + 1);

  if (NumReq < 2 || NumReq > NumReqMax || GapCycles < 1 || TimeoutCycles < 2) begin : g_bad_param
    $error("spi_bus_arbiter: illegal parameter set");
  end

  arb_state_e        state_q, state_d;
  logic [NumReq-1:0] gnt_q, gnt_d, pick_req, pick_oh;
  logic [OwnerW-1:0] owner_q, owner_d, ptr_q, ptr_d, pick_idx, owner_nxt;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              busy_q, busy_d, timeout_q, timeout_d;
  logic              pick_vld, release_c, revoke_c, grant_c;

`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
  localparam int TmoW = $clog2(TimeoutCycles);
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [NumReq-1:0] lock_q, lock_d;
  assign revoke_c = state_q == ARB_GRANT && req_i[owner_q] && tmo_q == TmoW'(TimeoutCycles - 1);
  assign pick_req = req_i & ~lock_q;
  // A revoked requester stays locked out until it is seen idle once.
  always_comb begin
    tmo_d = (state_q == ARB_GRANT) ? tmo_q + 1'b1 : '0;
    lock_d = (lock_q & req_i) | (revoke_c ? gnt_q : '0);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= '0;
      lock_q <= '0;
    end else begin
      tmo_q <= tmo_d;
      lock_q <= lock_d;
    end
  end
`else
  assign revoke_c = 1'b0;
  assign pick_req = req_i;
`endif

  spi_bus_arbiter_rr_pick #(.N(NumReq), .W(OwnerW)) u_pick (
    .req_i   (pick_req),
    .ptr_i   (ptr_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx),
    .onehot_o(pick_oh)
  );

  assign release_c = state_q == ARB_GRANT && (!req_i[owner_q] || revoke_c);
  assign owner_nxt = (owner_q == OwnerW'(NumReq - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    gap_d = gap_q;
    timeout_d = revoke_c;
    if (state_q == ARB_IDLE && pick_vld) begin
      state_d = ARB_GRANT;
      gnt_d = pick_oh;
      owner_d = pick_idx;
    end else if (release_c) begin
      state_d = ARB_GAP;
      gnt_d = '0;
      ptr_d = owner_nxt;
      gap_d = GapW'(GapCycles - 1);
    end else if (state_q == ARB_GAP) begin
      state_d = (gap_q == '0) ? ARB_IDLE : ARB_GAP;
      gap_d = (gap_q == '0) ? '0 : gap_q - 1'b1;
    end
    busy_d = state_d != ARB_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      gnt_q <= '0;
      owner_q <= '0;
      ptr_q <= '0;
      gap_q <= '0;
      busy_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      gap_q <= gap_d;
      busy_q <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_o = gnt_q;
  assign owner_o = owner_q;
  assign busy_o = busy_q;
  assign timeout_o = timeout_q;

  // Pins idle whenever nobody owns the bus; reset therefore lifts CS at once.
  assign grant_c = state_q == ARB_GRANT;
  assign spi_cs_no = grant_c ? req_cs_ni[owner_q] : 1'b1;
  assign spi_sclk_o = grant_c & req_sclk_i[owner_q];
  assign spi_copi_o = grant_c & req_copi_i[owner_q];
  assign req_cipo_o = {NumReq{grant_c & spi_cipo_i}} & gnt_q;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: directed checks of grant timing, round robin, gap, isolation and timeout.
module tb_spi_bus_arbiter;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [2:0] req_i = '0;
  logic [2:0] gnt_o;
  logic [1:0] owner_o;
  logic       busy_o, timeout_o;
  logic [2:0] req_sclk_i = '0;
  logic [2:0] req_copi_i = '0;
  logic [2:0] req_cs_ni = 3'b111;
  logic [2:0] req_cipo_o;
  logic       spi_sclk_o, spi_copi_o, spi_cs_no;
  logic       spi_cipo_i = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;

  spi_bus_arbiter #(.NumReq(3), .GapCycles(4), .TimeoutCycles(16)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .owner_o   (owner_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o),
    .req_sclk_i(req_sclk_i),
    .req_copi_i(req_copi_i),
    .req_cs_ni (req_cs_ni),
    .req_cipo_o(req_cipo_o),
    .spi_sclk_o(spi_sclk_o),
    .spi_copi_o(spi_copi_o),
    .spi_cs_no (spi_cs_no),
    .spi_cipo_i(spi_cipo_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    req_i = '0;
    req_sclk_i = '0;
    req_copi_i = '0;
    req_cs_ni = 3'b111;
    spi_cipo_i = 1'b0;
    rst_ni = 1'b0;
    step(1);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #2;
    n_tests++;
    if ({gnt_o, owner_o, busy_o, timeout_o} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_regs: got gnt=%b owner=%0d busy=%b tmo=%b want all 0", gnt_o, owner_o, busy_o, timeout_o);
    end
    n_tests++;
    if ({spi_cs_no, spi_sclk_o, spi_copi_o, req_cipo_o} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_pins: got cs=%b sclk=%b copi=%b cipo=%b want 1 0 0 000", spi_cs_no, spi_sclk_o, spi_copi_o, req_cipo_o);
    end
    apply_reset();
    req_i = 3'b001;
    req_cs_ni = 3'b110;
    step(1);
    n_tests++;
    if (gnt_o !== 3'b001 || spi_cs_no !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pre_grant: got gnt=%b cs=%b want 001 0", gnt_o, spi_cs_no);
    end
    rst_ni = 1'b0;
    #1;
    n_tests++;
    if (spi_cs_no !== 1'b1 || gnt_o !== 3'b000 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got cs=%b gnt=%b busy=%b want 1 000 0", spi_cs_no, gnt_o, busy_o);
    end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    req_i = 3'b010;
    step(1);
    n_tests++;
    if (gnt_o !== 3'b010 || owner_o !== 2'd1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: got gnt=%b owner=%0d busy=%b want 010 1 1", gnt_o, owner_o, busy_o);
    end
    req_cs_ni = 3'b101;
    req_sclk_i = 3'b010;
    req_copi_i = 3'b010;
    spi_cipo_i = 1'b1;
    #1;
    n_tests++;
    if ({spi_cs_no, spi_sclk_o, spi_copi_o, req_cipo_o} !== 6'b011010) begin
      n_fail++;
      $display("FAIL single_pins: got cs=%b sclk=%b copi=%b cipo=%b want 0 1 1 010", spi_cs_no, spi_sclk_o, spi_copi_o, req_cipo_o);
    end
    spi_cipo_i = 1'b0;
    #1;
    n_tests++;
    if (req_cipo_o !== 3'b000) begin
      n_fail++;
      $display("FAIL single_cipo_low: got %b want 000", req_cipo_o);
    end
    req_cs_ni = 3'b111;
    req_sclk_i = '0;
    req_copi_i = '0;
    req_i = '0;
    step(1);
    n_tests++;
    if (gnt_o !== 3'b000 || busy_o !== 1'b1 || owner_o !== 2'd1) begin
      n_fail++;
      $display("FAIL single_release: got gnt=%b busy=%b owner=%0d want 000 1 1", gnt_o, busy_o, owner_o);
    end
    step(4);
    n_tests++;
    if (busy_o !== 1'b0 || owner_o !== 2'd1) begin
      n_fail++;
      $display("FAIL single_idle: got busy=%b owner=%0d want 0 1", busy_o, owner_o);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp;
    int         e;
    apply_reset();
    req_cs_ni = 3'b000;
    req_i = 3'b111;
    step(1);
    for (int r = 0; r < 4; r++) begin
      e = r % 3;
      exp = 3'b001 << e;
      n_tests++;
      if (gnt_o !== exp || owner_o !== 2'(e) || spi_cs_no !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got gnt=%b owner=%0d cs=%b want %b %0d 0", r, gnt_o, owner_o, spi_cs_no, exp, e);
      end
      step(9);
      req_i[e] = 1'b0;
      step(1);
      req_i[e] = 1'b1;
      for (int g = 0; g < 4; g++) begin
        n_tests++;
        if (gnt_o !== 3'b000 || spi_cs_no !== 1'b1) begin
          n_fail++;
          $display("FAIL rr_gap%0d_%0d: got gnt=%b cs=%b want 000 1", r, g, gnt_o, spi_cs_no);
        end
        step(1);
      end
      step(1);
    end
  endtask

  task automatic test_gap();
    apply_reset();
    req_i = 3'b001;
    step(1);
    req_i = 3'b101;
    step(3);
    n_tests++;
    if (gnt_o !== 3'b001) begin
      n_fail++;
      $display("FAIL gap_hold: got %b want 001", gnt_o);
    end
    req_i = 3'b100;
    step(1);
    for (int g = 1; g <= 4; g++) begin
      n_tests++;
      if (gnt_o !== 3'b000 || spi_cs_no !== 1'b1 || busy_o !== 1'b1 || owner_o !== 2'd0) begin
        n_fail++;
        $display("FAIL gap_t%0d: got gnt=%b cs=%b busy=%b owner=%0d want 000 1 1 0", g, gnt_o, spi_cs_no, busy_o, owner_o);
      end
      step(1);
    end
    n_tests++;
    if (gnt_o !== 3'b000 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_t5: got gnt=%b busy=%b want 000 0", gnt_o, busy_o);
    end
    step(1);
    n_tests++;
    if (gnt_o !== 3'b100 || owner_o !== 2'd2) begin
      n_fail++;
      $display("FAIL gap_t6: got gnt=%b owner=%0d want 100 2", gnt_o, owner_o);
    end
  endtask

  task automatic test_isolation();
    logic b;
    apply_reset();
    req_i = 3'b010;
    step(1);
    req_cs_ni = 3'b101;
    spi_cipo_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      b = j[0];
      req_sclk_i = {b, 1'b0, b};
      req_copi_i = {b, 1'b0, b};
      req_cs_ni = {~b, 1'b0, ~b};
      #1;
      n_tests++;
      if ({spi_cs_no, spi_sclk_o, spi_copi_o, req_cipo_o} !== 6'b000010) begin
        n_fail++;
        $display("FAIL iso_%0d: got cs=%b sclk=%b copi=%b cipo=%b want 0 0 0 010", j, spi_cs_no, spi_sclk_o, spi_copi_o, req_cipo_o);
      end
    end
    req_i = 3'b011;
    step(2);
    req_i = 3'b010;
    step(1);
    req_i = 3'b000;
    req_cs_ni = 3'b111;
    spi_cipo_i = 1'b0;
    step(6);
    n_tests++;
    if (gnt_o !== 3'b000 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL iso_lost_req: got gnt=%b busy=%b want 000 0", gnt_o, busy_o);
    end
  endtask

`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    int pulses = 0;
    apply_reset();
    req_i = 3'b001;
    step(1);
    step(15);
    n_tests++;
    if (gnt_o !== 3'b001 || timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_before: got gnt=%b tmo=%b want 001 0", gnt_o, timeout_o);
    end
    step(1);
    n_tests++;
    if (gnt_o !== 3'b000 || timeout_o !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_revoke: got gnt=%b tmo=%b want 000 1", gnt_o, timeout_o);
    end
    for (int c = 0; c < 12; c++) begin
      step(1);
      pulses += int'(timeout_o);
      n_tests++;
      if (gnt_o !== 3'b000) begin
        n_fail++;
        $display("FAIL tmo_lockout%0d: got gnt=%b want 000", c, gnt_o);
      end
    end
    n_tests++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL tmo_single_pulse: got %0d extra pulses want 0", pulses);
    end
    req_i = 3'b000;
    step(1);
    req_i = 3'b001;
    step(1);
    n_tests++;
    if (gnt_o !== 3'b001) begin
      n_fail++;
      $display("FAIL tmo_regrant: got %b want 001", gnt_o);
    end
  endtask
`else
  task automatic test_timeout();
    int pulses = 0;
    apply_reset();
    req_i = 3'b001;
    step(1);
    for (int c = 0; c < 40; c++) begin
      step(1);
      pulses += int'(timeout_o);
    end
    n_tests++;
    if (gnt_o !== 3'b001 || pulses !== 0) begin
      n_fail++;
      $display("FAIL tmo_unbounded: got gnt=%b pulses=%0d want 001 0", gnt_o, pulses);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_gap();
    test_isolation();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
